// File: rtl/cpu_mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mpu_pkg
// Purpose : Shared types and helpers for the cpu_mpu_ex memory protection unit.
//           Holds the descriptor bit positions, the fault cause encoding, the
//           stored region record and the size <-> mask conversions.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cpu_mpu_pkg;

    // Descriptor layout: [31:12] base, [10] X, [7] lock, [5] W, [4] R, [3:0] size
    localparam int c_base_lsb = 12;
    localparam int c_x_bit    = 10;
    localparam int c_lock_bit = 7;
    localparam int c_w_bit    = 5;
    localparam int c_r_bit    = 4;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_LOAD  = 2'd1,
        CAUSE_STORE = 2'd2,
        CAUSE_EXEC  = 2'd3
    } fault_cause_t;

    typedef struct packed {
        logic [19:0] base;
        logic [19:0] mask;
        logic        x;
        logic        w;
        logic        r;
        logic        lock;
        logic        valid;
    } region_t;

    // Region of 2^size 4KB pages: clear the low 'size' bits of the page mask.
    function automatic logic [19:0] size_to_mask(input logic [3:0] size);
        return ~((20'd1 << size) - 20'd1);
    endfunction

    // Inverse of size_to_mask: number of cleared mask bits.
    function automatic logic [3:0] mask_to_size(input logic [19:0] mask);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 20; i++) begin
            if (!mask[i]) begin
                cnt = cnt + 4'd1;
            end
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mpu_match.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mpu_match
// Purpose : Single-region address comparator. Reports, per permission, whether
//           the page address falls inside a valid region granting it.
// Ports   : page   in  20  address bits [31:12]
//           region in      stored region record
//           hit_r  out 1   inside region and region grants read
//           hit_w  out 1   inside region and region grants write
//           hit_x  out 1   inside region and region grants execute
// Revision: 1.0 - initial release
// ============================================================================
module cpu_mpu_match
    import cpu_mpu_pkg::*;
(
    input  logic [19:0] page,
    input  region_t     region,
    output logic        hit_r,
    output logic        hit_w,
    output logic        hit_x
);

    logic in_region;

    // Base bits under the mask hole are don't-care, so unaligned bases still match.
    assign in_region = region.valid && (((page ^ region.base) & region.mask) == 20'd0);

    assign hit_r = in_region & region.r;
    assign hit_w = in_region & region.w;
    assign hit_x = in_region & region.x;

endmodule
`default_nettype wire

// File: rtl/cpu_mpu_ex.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mpu_ex
// Purpose : Parametrised memory protection unit. Checks user-mode data
//           accesses and instruction fetches against NUM_REGIONS programmable
//           regions (R/W/X), registers faults into p4, supports lockable
//           regions, indexed writes, readback and a sticky fault capture.
// Ports   : clock, reset (async active-low)
//           p3_mem_request/p3_mem_write/p3_mem_addr   data access
//           ifetch_request/ifetch_addr                instruction fetch
//           supervisor_mode                           bypass all checks
//           p3_mpu_reset/p3_mpu_add/p3_mpu_wr         config commands
//           p3_mpu_index/p3_mpu_data                  config slot / descriptor
//           p3_fault_clear                            clear fault capture
//           p4_load/store/exec_fault                  registered faults
//           p4_region_rdata                           registered readback
//           fault_valid/fault_addr/fault_cause        sticky capture
//           add_overflow                              add dropped (all locked)
// Revision: 1.0 - initial release
// ============================================================================
module cpu_mpu_ex
    import cpu_mpu_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             p3_mem_request,
    input  logic             p3_mem_write,
    input  logic [31:0]      p3_mem_addr,
    input  logic             ifetch_request,
    input  logic [31:0]      ifetch_addr,
    input  logic             supervisor_mode,
    input  logic             p3_mpu_reset,
    input  logic             p3_mpu_add,
    input  logic             p3_mpu_wr,
    input  logic [IDX_W-1:0] p3_mpu_index,
    input  logic [31:0]      p3_mpu_data,
    input  logic             p3_fault_clear,
    output logic             p4_load_fault,
    output logic             p4_store_fault,
    output logic             p4_exec_fault,
    output logic [31:0]      p4_region_rdata,
    output logic             fault_valid,
    output logic [31:0]      fault_addr,
    output logic [1:0]       fault_cause,
    output logic             add_overflow
);

    region_t          slots_q [NUM_REGIONS];
    region_t          slots_d [NUM_REGIONS];
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             add_overflow_q, add_overflow_d;
    logic             load_fault_q, load_fault_d;
    logic             store_fault_q, store_fault_d;
    logic             exec_fault_q, exec_fault_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             fault_valid_q, fault_valid_d;
    logic [31:0]      fault_addr_q, fault_addr_d;
    fault_cause_t     fault_cause_q, fault_cause_d;

    logic [NUM_REGIONS-1:0] d_hit_r, d_hit_w, d_hit_x;
    logic [NUM_REGIONS-1:0] f_hit_r, f_hit_w, f_hit_x;

    region_t          new_region;
    logic             new_has_perm;
    logic             add_found;
    logic [IDX_W-1:0] add_slot;
    logic             unused_bits;

    // ------------------------------------------------------------------
    // Region comparators, one per slot for each port
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        cpu_mpu_match u_data_match (
            .page   (p3_mem_addr[31:12]),
            .region (slots_q[g]),
            .hit_r  (d_hit_r[g]),
            .hit_w  (d_hit_w[g]),
            .hit_x  (d_hit_x[g])
        );
        cpu_mpu_match u_fetch_match (
            .page   (ifetch_addr[31:12]),
            .region (slots_q[g]),
            .hit_r  (f_hit_r[g]),
            .hit_w  (f_hit_w[g]),
            .hit_x  (f_hit_x[g])
        );
    end

    // Data port never needs X, fetch port never needs R/W; reserved descriptor bits are don't-care.
    assign unused_bits = ^{d_hit_x, f_hit_r, f_hit_w,
                           p3_mpu_data[11], p3_mpu_data[9:8], p3_mpu_data[6]};

    // ------------------------------------------------------------------
    // Descriptor decode
    // ------------------------------------------------------------------
    always_comb begin
        new_region       = '0;
        new_region.base  = p3_mpu_data[31:c_base_lsb];
        new_region.mask  = size_to_mask(p3_mpu_data[3:0]);
        new_region.x     = p3_mpu_data[c_x_bit];
        new_region.w     = p3_mpu_data[c_w_bit];
        new_region.r     = p3_mpu_data[c_r_bit];
        new_region.lock  = p3_mpu_data[c_lock_bit];
        new_region.valid = 1'b1;
        new_has_perm     = p3_mpu_data[c_x_bit] | p3_mpu_data[c_w_bit] | p3_mpu_data[c_r_bit];
    end

    // First unlocked slot at or after the replacement pointer, wrapping.
    always_comb begin
        logic [IDX_W-1:0] cand;
        add_found = 1'b0;
        add_slot  = ptr_q;
        cand      = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!add_found && !slots_q[cand].lock) begin
                add_found = 1'b1;
                add_slot  = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration: reset > indexed write > add
    // ------------------------------------------------------------------
    always_comb begin
        slots_d        = slots_q;
        ptr_d          = ptr_q;
        add_overflow_d = 1'b0;
        if (p3_mpu_reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (!slots_q[i].lock) begin
                    slots_d[i] = '0;
                end
            end
            ptr_d = '0;
        end else if (p3_mpu_wr) begin
            if (!slots_q[p3_mpu_index].lock) begin
                if (!new_has_perm && !new_region.lock) begin
                    slots_d[p3_mpu_index] = '0;
                end else begin
                    slots_d[p3_mpu_index] = new_region;
                end
            end
        end else if (p3_mpu_add && new_has_perm) begin
            if (add_found) begin
                slots_d[add_slot] = new_region;
                ptr_d             = add_slot + 1'b1;
            end else begin
                add_overflow_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Permission checks and readback (uses pre-update slot state)
    // ------------------------------------------------------------------
    always_comb begin
        load_fault_d  = p3_mem_request & ~supervisor_mode & ~p3_mem_write & ~(|d_hit_r);
        store_fault_d = p3_mem_request & ~supervisor_mode &  p3_mem_write & ~(|d_hit_w);
        exec_fault_d  = ifetch_request & ~supervisor_mode & ~(|f_hit_x);

        rdata_d = '0;
        if (slots_q[p3_mpu_index].valid) begin
            rdata_d[31:c_base_lsb] = slots_q[p3_mpu_index].base;
            rdata_d[c_x_bit]       = slots_q[p3_mpu_index].x;
            rdata_d[c_lock_bit]    = slots_q[p3_mpu_index].lock;
            rdata_d[c_w_bit]       = slots_q[p3_mpu_index].w;
            rdata_d[c_r_bit]       = slots_q[p3_mpu_index].r;
            rdata_d[3:0]           = mask_to_size(slots_q[p3_mpu_index].mask);
        end
    end

    // ------------------------------------------------------------------
    // Sticky fault capture. Captured on the same edge that raises the p4
    // fault; a clear in the same cycle lets the new fault in. Data wins
    // over exec when both fault together.
    // ------------------------------------------------------------------
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        fault_cause_d = fault_cause_q;
        if (p3_fault_clear) begin
            fault_valid_d = 1'b0;
            fault_addr_d  = '0;
            fault_cause_d = CAUSE_NONE;
        end
        if (!fault_valid_d) begin
            if (load_fault_d || store_fault_d) begin
                fault_valid_d = 1'b1;
                fault_addr_d  = p3_mem_addr;
                fault_cause_d = store_fault_d ? CAUSE_STORE : CAUSE_LOAD;
            end else if (exec_fault_d) begin
                fault_valid_d = 1'b1;
                fault_addr_d  = ifetch_addr;
                fault_cause_d = CAUSE_EXEC;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                slots_q[i] <= '0;
            end
            ptr_q          <= '0;
            add_overflow_q <= 1'b0;
            load_fault_q   <= 1'b0;
            store_fault_q  <= 1'b0;
            exec_fault_q   <= 1'b0;
            rdata_q        <= '0;
            fault_valid_q  <= 1'b0;
            fault_addr_q   <= '0;
            fault_cause_q  <= CAUSE_NONE;
        end else begin
            slots_q        <= slots_d;
            ptr_q          <= ptr_d;
            add_overflow_q <= add_overflow_d;
            load_fault_q   <= load_fault_d;
            store_fault_q  <= store_fault_d;
            exec_fault_q   <= exec_fault_d;
            rdata_q        <= rdata_d;
            fault_valid_q  <= fault_valid_d;
            fault_addr_q   <= fault_addr_d;
            fault_cause_q  <= fault_cause_d;
        end
    end

    assign p4_load_fault   = load_fault_q;
    assign p4_store_fault  = store_fault_q;
    assign p4_exec_fault   = exec_fault_q;
    assign p4_region_rdata = rdata_q;
    assign fault_valid     = fault_valid_q;
    assign fault_addr      = fault_addr_q;
    assign fault_cause     = fault_cause_q;
    assign add_overflow    = add_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mpu_ex.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_mpu_ex
// Purpose : Directed self-checking bench for cpu_mpu_ex (16 regions).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_mpu_ex;

    localparam int NUM_REGIONS = 16;
    localparam int IDX_W       = 4;

    logic             clock;
    logic             reset;
    logic             p3_mem_request;
    logic             p3_mem_write;
    logic [31:0]      p3_mem_addr;
    logic             ifetch_request;
    logic [31:0]      ifetch_addr;
    logic             supervisor_mode;
    logic             p3_mpu_reset;
    logic             p3_mpu_add;
    logic             p3_mpu_wr;
    logic [IDX_W-1:0] p3_mpu_index;
    logic [31:0]      p3_mpu_data;
    logic             p3_fault_clear;
    logic             p4_load_fault;
    logic             p4_store_fault;
    logic             p4_exec_fault;
    logic [31:0]      p4_region_rdata;
    logic             fault_valid;
    logic [31:0]      fault_addr;
    logic [1:0]       fault_cause;
    logic             add_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mpu_ex #(.NUM_REGIONS(NUM_REGIONS)) u_dut (
        .clock           (clock),
        .reset           (reset),
        .p3_mem_request  (p3_mem_request),
        .p3_mem_write    (p3_mem_write),
        .p3_mem_addr     (p3_mem_addr),
        .ifetch_request  (ifetch_request),
        .ifetch_addr     (ifetch_addr),
        .supervisor_mode (supervisor_mode),
        .p3_mpu_reset    (p3_mpu_reset),
        .p3_mpu_add      (p3_mpu_add),
        .p3_mpu_wr       (p3_mpu_wr),
        .p3_mpu_index    (p3_mpu_index),
        .p3_mpu_data     (p3_mpu_data),
        .p3_fault_clear  (p3_fault_clear),
        .p4_load_fault   (p4_load_fault),
        .p4_store_fault  (p4_store_fault),
        .p4_exec_fault   (p4_exec_fault),
        .p4_region_rdata (p4_region_rdata),
        .fault_valid     (fault_valid),
        .fault_addr      (fault_addr),
        .fault_cause     (fault_cause),
        .add_overflow    (add_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        p3_mem_request  = 1'b0;
        p3_mem_write    = 1'b0;
        p3_mem_addr     = '0;
        ifetch_request  = 1'b0;
        ifetch_addr     = '0;
        supervisor_mode = 1'b0;
        p3_mpu_reset    = 1'b0;
        p3_mpu_add      = 1'b0;
        p3_mpu_wr       = 1'b0;
        p3_mpu_data     = '0;
        p3_fault_clear  = 1'b0;
    endtask

    task automatic outs_zero(input string pfx);
        check({pfx, "_ld"},    32'(p4_load_fault),  32'd0);
        check({pfx, "_st"},    32'(p4_store_fault), 32'd0);
        check({pfx, "_ex"},    32'(p4_exec_fault),  32'd0);
        check({pfx, "_rd"},    p4_region_rdata,     32'd0);
        check({pfx, "_fv"},    32'(fault_valid),    32'd0);
        check({pfx, "_fa"},    fault_addr,          32'd0);
        check({pfx, "_fc"},    32'(fault_cause),    32'd0);
        check({pfx, "_ovf"},   32'(add_overflow),   32'd0);
    endtask

    task automatic add(input logic [31:0] desc);
        p3_mpu_add = 1'b1; p3_mpu_data = desc; tick(); clr();
    endtask

    task automatic wr(input logic [IDX_W-1:0] idx, input logic [31:0] desc);
        p3_mpu_wr = 1'b1; p3_mpu_index = idx; p3_mpu_data = desc; tick(); clr();
    endtask

    task automatic mpu_reset();
        p3_mpu_reset = 1'b1; tick(); clr();
    endtask

    task automatic rb(input logic [IDX_W-1:0] idx, input logic [31:0] exp, input string tag);
        p3_mpu_index = idx; tick(); check(tag, p4_region_rdata, exp);
    endtask

    // One p3 cycle of data and/or fetch traffic.
    task automatic access(input logic req, input logic wrt, input logic [31:0] addr,
                          input logic freq, input logic [31:0] faddr,
                          input logic sup, input logic fclr);
        p3_mem_request = req;  p3_mem_write = wrt;  p3_mem_addr = addr;
        ifetch_request = freq; ifetch_addr  = faddr;
        supervisor_mode = sup; p3_fault_clear = fclr;
        tick(); clr();
    endtask

    initial begin
        clr();
        p3_mpu_index = '0;
        reset = 1'b0;
        #2;
        outs_zero("rst");
        tick(); tick();
        reset = 1'b1;

        // R-only 16KB region at 0x80000000
        add(32'h8000_0012);
        rb(4'd0, 32'h8000_0012, "rb_add0");
        access(1, 0, 32'h8000_3FFC, 0, 0, 0, 0);
        check("ld_inside",  32'(p4_load_fault), 32'd0);
        check("fv_none",    32'(fault_valid),   32'd0);
        access(1, 0, 32'h8000_4000, 0, 0, 0, 0);
        check("ld_outside", 32'(p4_load_fault), 32'd1);
        check("fv_set",     32'(fault_valid),   32'd1);
        check("faddr_1",    fault_addr,         32'h8000_4000);
        check("fcause_1",   32'(fault_cause),   32'd1);

        // W+X 4KB region at 0x00400000 lands in slot 1
        add(32'h0040_0420);
        access(1, 1, 32'h0040_0010, 1, 32'h0040_0010, 0, 0);
        check("st_wx",      32'(p4_store_fault), 32'd0);
        check("ex_wx",      32'(p4_exec_fault),  32'd0);
        access(1, 0, 32'h0040_0010, 1, 32'h8000_0000, 0, 0);
        check("ld_noR",     32'(p4_load_fault),  32'd1);
        check("ex_noX",     32'(p4_exec_fault),  32'd1);
        check("faddr_stk",  fault_addr,          32'h8000_4000);

        // Supervisor bypass with no regions
        mpu_reset();
        rb(4'd1, 32'd0, "rb_after_rst");
        access(1, 1, 32'h0040_0010, 0, 0, 1, 0);
        check("st_sup",     32'(p4_store_fault), 32'd0);
        access(1, 1, 32'h0040_0010, 0, 0, 0, 0);
        check("st_user",    32'(p4_store_fault), 32'd1);

        // Config takes effect only in the following cycle
        p3_mpu_add = 1'b1; p3_mpu_data = 32'h0040_0420;
        access(1, 1, 32'h0040_0010, 0, 0, 0, 0);
        check("no_bypass",  32'(p4_store_fault), 32'd1);
        access(1, 1, 32'h0040_0010, 0, 0, 0, 0);
        check("next_cycle", 32'(p4_store_fault), 32'd0);

        // Fault capture sequencing
        access(0, 0, 0, 0, 0, 0, 1);
        check("clr_fv",     32'(fault_valid),   32'd0);
        check("clr_fc",     32'(fault_cause),   32'd0);
        access(1, 0, 32'h0000_1000, 0, 0, 0, 0);
        access(1, 1, 32'h0000_2000, 0, 0, 0, 0);
        check("st_b2b",     32'(p4_store_fault), 32'd1);
        check("faddr_b2b",  fault_addr,          32'h0000_1000);
        check("fcause_b2b", 32'(fault_cause),    32'd1);
        access(0, 0, 0, 1, 32'h0000_3000, 0, 1);
        check("ex_clr",     32'(p4_exec_fault), 32'd1);
        check("faddr_clr",  fault_addr,         32'h0000_3000);
        check("fcause_clr", 32'(fault_cause),   32'd3);
        access(1, 0, 32'h0000_5000, 1, 32'h0000_6000, 0, 1);
        check("both_ld",    32'(p4_load_fault), 32'd1);
        check("both_ex",    32'(p4_exec_fault), 32'd1);
        check("faddr_both", fault_addr,         32'h0000_5000);
        check("fcause_both",32'(fault_cause),   32'd1);

        // Fill all slots, slot 3 locked
        mpu_reset();
        for (int i = 0; i < NUM_REGIONS; i++) begin
            add(32'h1000_0010 | (32'(i) << 12) | ((i == 3) ? 32'h80 : 32'h0));
        end
        mpu_reset();
        access(1, 0, 32'h1000_3000, 0, 0, 0, 0);
        check("lock_keeps", 32'(p4_load_fault), 32'd0);
        access(1, 0, 32'h1000_5000, 0, 0, 0, 0);
        check("unlock_gone",32'(p4_load_fault), 32'd1);
        rb(4'd3, 32'h1000_3090, "rb_lock3");
        rb(4'd0, 32'd0,         "rb_clr0");
        add(32'h2000_0010);
        rb(4'd0, 32'h2000_0010, "rb_ptr0");
        add(32'h2000_1010);
        add(32'h2000_2010);
        add(32'h2000_4010);
        rb(4'd4, 32'h2000_4010, "rb_skip3");
        wr(4'd3, 32'h3000_0010);
        rb(4'd3, 32'h1000_3090, "wr_locked");

        // Indexed write outranks add in the same cycle; ptr is now 5
        p3_mpu_add = 1'b1;
        wr(4'd7, 32'h4000_7030);
        rb(4'd5, 32'd0,         "prio_add");
        rb(4'd7, 32'h4000_7030, "prio_wr");
        add(32'h5000_0000);
        rb(4'd5, 32'd0,         "add_noperm");
        wr(4'd7, 32'h0000_0000);
        rb(4'd7, 32'd0,         "wr_inval");

        // Lock every slot, then overflow
        for (int i = 0; i < NUM_REGIONS; i++) begin
            wr(4'(i), 32'h6000_0090 | (32'(i) << 12));
        end
        add(32'h7000_0010);
        check("ovf_pulse",  32'(add_overflow), 32'd1);
        tick();
        check("ovf_once",   32'(add_overflow), 32'd0);
        rb(4'd0, 32'h6000_0090, "rb_ovf0");
        rb(4'd3, 32'h1000_3090, "rb_ovf3");
        mpu_reset();
        rb(4'd5, 32'h6000_5090, "rb_lockall");

        // Hard reset mid-add with a captured fault
        access(1, 0, 32'h0000_0000, 0, 0, 0, 1);
        check("pre_fv",     32'(fault_valid), 32'd1);
        p3_mpu_index = 4'd3;
        tick();
        p3_mpu_add = 1'b1; p3_mpu_data = 32'h0000_0010;
        p3_mem_request = 1'b1; p3_mem_addr = 32'h0000_0000;
        reset = 1'b0;
        #1;
        outs_zero("arst");
        clr();
        tick();
        reset = 1'b1;
        rb(4'd0, 32'd0, "arst_slot0");
        rb(4'd3, 32'd0, "arst_slot3");
        add(32'h0000_8010);
        rb(4'd0, 32'h0000_8010, "arst_ptr0");
        wr(4'd3, 32'h0000_3010);
        rb(4'd3, 32'h0000_3010, "arst_unlock");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
